// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer read arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_SEC  = 2'd2
    } fb_tag_t;

    // One spare bit above the pixel-count address range.
    function automatic int unsigned fb_addr_w(input int unsigned w, input int unsigned h);
        return int'($clog2(w * h)) + 1;
    endfunction

endpackage

// File: rtl/fb_rsp_fifo.sv
// First-word-fall-through response FIFO; rd_data reads 0 while empty.
module fb_rsp_fifo #(
    parameter  int unsigned DATA_W = 12,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fb_read_arbiter.sv
// Framebuffer read-port arbiter: VGA scanout always wins, a credited secondary reader fills idle slots.
// Optional statistics counters are built when FB_ARB_STATS_EN is defined.
module fb_read_arbiter
    import fb_arb_pkg::*;
#(
    parameter  int unsigned RESOLUTION_WIDTH  = 640,
    parameter  int unsigned RESOLUTION_HEIGHT = 480,
    parameter  int unsigned DATA_W            = 12,
    parameter  int unsigned RD_LAT            = 1,
    parameter  int unsigned RSP_DEPTH         = 4,
    localparam int unsigned ADDR_W            = fb_addr_w(RESOLUTION_WIDTH, RESOLUTION_HEIGHT)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_dv,
    input  logic              sec_req_valid,
    output logic              sec_req_ready,
    input  logic [ADDR_W-1:0] sec_addr,
    output logic              sec_rsp_valid,
    input  logic              sec_rsp_ready,
    output logic [DATA_W-1:0] sec_rsp_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stat_clr,
    output logic [15:0]       stat_grants,
    output logic [15:0]       stat_blocked
);

    localparam int unsigned CRED_W = $clog2(RSP_DEPTH + 1);

    fb_tag_t           tag_q [RD_LAT];
    fb_tag_t           issue_tag;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic [CRED_W-1:0] fifo_count;
    logic [DATA_W-1:0] fifo_data;
    logic              sec_grant, rsp_push, rsp_pop, fifo_full, fifo_empty;

    // Issue: VGA first, then secondary if a response slot is reserved for it.
    always_comb begin
        mem_en        = 1'b0;
        mem_addr      = '0;
        issue_tag     = TAG_NONE;
        sec_grant     = 1'b0;
        sec_req_ready = !rst && !vga_req && (credits_q != '0);
        if (vga_req) begin
            mem_en    = 1'b1;
            mem_addr  = vga_addr;
            issue_tag = TAG_VGA;
        end else if (sec_req_valid && sec_req_ready) begin
            mem_en    = 1'b1;
            mem_addr  = sec_addr;
            issue_tag = TAG_SEC;
            sec_grant = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
        end else begin
            tag_q[0] <= issue_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Last tag stage lines up with mem_rdata and routes it.
    always_comb begin
        vga_dv   = 1'b0;
        vga_data = '0;
        rsp_push = 1'b0;
        if (!rst) begin
            if (tag_q[RD_LAT-1] == TAG_VGA) begin
                vga_dv   = 1'b1;
                vga_data = mem_rdata;
            end else if (tag_q[RD_LAT-1] == TAG_SEC) begin
                rsp_push = 1'b1;
            end
        end
    end

    fb_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (pclk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (mem_rdata),
        .pop       (rsp_pop),
        .rd_data   (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sec_rsp_valid = !rst && !fifo_empty;
    assign sec_rsp_data  = sec_rsp_valid ? fifo_data : '0;
    assign rsp_pop       = sec_rsp_valid && sec_rsp_ready;

    // Credits = FIFO slots not yet claimed by a granted or buffered read.
    always_comb begin
        credits_d = credits_q;
        if (sec_grant && !rsp_pop)      credits_d = credits_q - CRED_W'(1);
        else if (rsp_pop && !sec_grant) credits_d = credits_q + CRED_W'(1);
    end

    always_ff @(posedge pclk) begin
        if (rst) credits_q <= CRED_W'(RSP_DEPTH);
        else     credits_q <= credits_d;
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            assert (!(rsp_push && fifo_full));
            assert (32'(credits_q) + 32'(fifo_count) <= RSP_DEPTH);
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d, stat_blocked_q, stat_blocked_d;

    always_comb begin
        stat_grants_d  = stat_grants_q;
        stat_blocked_d = stat_blocked_q;
        if (stat_clr) begin
            stat_grants_d  = '0;
            stat_blocked_d = '0;
        end else begin
            if (sec_grant && stat_grants_q != 16'hFFFF)
                stat_grants_d = stat_grants_q + 16'd1;
            if (sec_req_valid && vga_req && stat_blocked_q != 16'hFFFF)
                stat_blocked_d = stat_blocked_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            stat_grants_q  <= '0;
            stat_blocked_q <= '0;
        end else begin
            stat_grants_q  <= stat_grants_d;
            stat_blocked_q <= stat_blocked_d;
        end
    end

    assign stat_grants  = stat_grants_q;
    assign stat_blocked = stat_blocked_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_grants     = '0;
    assign stat_blocked    = '0;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Randomized self-checking bench for fb_read_arbiter against a transaction-level model.
module tb_fb_read_arbiter;
    import fb_arb_pkg::*;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned RD_LAT    = 3;
    localparam int unsigned RSP_DEPTH = 4;
    localparam int unsigned ADDR_W    = fb_addr_w(640, 480);

    logic              pclk = 1'b0;
    logic              rst;
    logic              vga_req, sec_req_valid, sec_rsp_ready, stat_clr;
    logic [ADDR_W-1:0] vga_addr, sec_addr, mem_addr;
    logic [DATA_W-1:0] vga_data, sec_rsp_data, mem_rdata;
    logic              vga_dv, sec_req_ready, sec_rsp_valid, mem_en;
    logic [15:0]       stat_grants, stat_blocked;

    fb_read_arbiter #(
        .RESOLUTION_WIDTH  (640),
        .RESOLUTION_HEIGHT (480),
        .DATA_W            (DATA_W),
        .RD_LAT            (RD_LAT),
        .RSP_DEPTH         (RSP_DEPTH)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .vga_req       (vga_req),
        .vga_addr      (vga_addr),
        .vga_data      (vga_data),
        .vga_dv        (vga_dv),
        .sec_req_valid (sec_req_valid),
        .sec_req_ready (sec_req_ready),
        .sec_addr      (sec_addr),
        .sec_rsp_valid (sec_rsp_valid),
        .sec_rsp_ready (sec_rsp_ready),
        .sec_rsp_data  (sec_rsp_data),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .stat_clr      (stat_clr),
        .stat_grants   (stat_grants),
        .stat_blocked  (stat_blocked)
    );

    always #5 pclk = ~pclk;

    function automatic logic [DATA_W-1:0] fb_pix(input logic [ADDR_W-1:0] a);
        return DATA_W'(a ^ (a >> 7) ^ ADDR_W'(20'h5A5));
    endfunction

    // Framebuffer model with fixed read latency; junk when not enabled.
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge pclk) begin
        rd_pipe[0] <= mem_en ? fb_pix(mem_addr) : DATA_W'(12'hBAD);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    typedef struct { int unsigned due; logic [DATA_W-1:0] data; } vga_item_t;
    typedef struct { int unsigned rdy; logic [ADDR_W-1:0] addr; } sec_item_t;

    vga_item_t   vga_q[$];
    sec_item_t   sec_q[$];
    int unsigned now;
    int unsigned m_grants, m_blocked;
    int unsigned n_checks, n_errors;
    logic        g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, now, obs, exp);
        end
    endtask

    // One clock: drive, check against the model, then advance the model across the edge.
    task automatic cycle(input logic vreq, input logic [ADDR_W-1:0] vaddr,
                         input logic sval, input logic [ADDR_W-1:0] saddr,
                         input logic rrdy, input logic clr, output logic granted);
        logic              rdy_e, en_e, dv_e, rv_e, pop_e;
        logic [ADDR_W-1:0] ad_e;
        logic [DATA_W-1:0] vd_e, rd_e;
        vga_req = vreq; vga_addr = vaddr;
        sec_req_valid = sval; sec_addr = saddr;
        sec_rsp_ready = rrdy; stat_clr = clr;
        #3;
        rdy_e   = !rst && !vreq && (sec_q.size() < RSP_DEPTH);
        granted = sval && rdy_e;
        en_e    = vreq || granted;
        ad_e    = vreq ? vaddr : (granted ? saddr : '0);
        dv_e    = !rst && vga_q.size() != 0 && vga_q[0].due == now;
        vd_e    = dv_e ? vga_q[0].data : '0;
        rv_e    = !rst && sec_q.size() != 0 && sec_q[0].rdy <= now;
        rd_e    = rv_e ? fb_pix(sec_q[0].addr) : '0;
        pop_e   = rv_e && rrdy;
        chk("mem_en", 32'(mem_en), 32'(en_e));
        chk("mem_addr", 32'(mem_addr), 32'(ad_e));
        chk("sec_req_ready", 32'(sec_req_ready), 32'(rdy_e));
        chk("vga_dv", 32'(vga_dv), 32'(dv_e));
        chk("vga_data", 32'(vga_data), 32'(vd_e));
        chk("sec_rsp_valid", 32'(sec_rsp_valid), 32'(rv_e));
        chk("sec_rsp_data", 32'(sec_rsp_data), 32'(rd_e));
`ifdef FB_ARB_STATS_EN
        chk("stat_grants", 32'(stat_grants), m_grants);
        chk("stat_blocked", 32'(stat_blocked), m_blocked);
`else
        chk("stat_grants", 32'(stat_grants), 32'd0);
        chk("stat_blocked", 32'(stat_blocked), 32'd0);
`endif
        if (rst) begin
            vga_q.delete();
            sec_q.delete();
        end else begin
            if (vga_q.size() != 0 && vga_q[0].due == now) void'(vga_q.pop_front());
            if (pop_e) void'(sec_q.pop_front());
            if (vreq)         vga_q.push_back('{now + RD_LAT, fb_pix(vaddr)});
            else if (granted) sec_q.push_back('{now + RD_LAT + 1, saddr});
        end
        if (rst || clr) begin
            m_grants  = 0;
            m_blocked = 0;
        end else begin
            if (granted && m_grants < 65535) m_grants++;
            if (sval && vreq && m_blocked < 65535) m_blocked++;
        end
        @(posedge pclk);
        #1;
        now++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        n_checks = 0; n_errors = 0; now = 0; m_grants = 0; m_blocked = 0;
        rst = 1'b1;
        vga_req = 1'b0; vga_addr = '0; sec_req_valid = 1'b0; sec_addr = '0;
        sec_rsp_ready = 1'b0; stat_clr = 1'b0;
        repeat (3) @(posedge pclk);
        #1;

        // Reset state: mem_en follows vga_req only, no secondary grant.
        cycle(1'b1, ADDR_W'(5), 1'b1, ADDR_W'(7), 1'b1, 1'b0, g);
        cycle(1'b0, '0, 1'b1, ADDR_W'(7), 1'b1, 1'b0, g);
        rst = 1'b0;

        // One full active line of VGA reads.
        for (int i = 0; i < 640; i++) cycle(1'b1, ADDR_W'(i), 1'b0, '0, 1'b0, 1'b0, g);
        repeat (6) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, g);

        // Fill all credits with responses held, then free one slot.
        a = 10;
        repeat (10) begin
            cycle(1'b0, '0, 1'b1, ADDR_W'(a), 1'b0, 1'b0, g);
            if (g) a++;
        end
        cycle(1'b0, '0, 1'b1, ADDR_W'(a), 1'b1, 1'b0, g);
        if (g) a++;
        repeat (4) begin
            cycle(1'b0, '0, (a <= 14), ADDR_W'(a), 1'b0, 1'b0, g);
            if (g) a++;
        end
        repeat (12) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, g);

        // VGA and secondary contend: VGA wins every cycle.
        for (int i = 0; i < 6; i++) cycle(1'b1, ADDR_W'(1000 + i), 1'b1, ADDR_W'(50), 1'b0, 1'b0, g);
        repeat (4) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, g);

        // Reset with one response buffered and two reads still in flight.
        cycle(1'b0, '0, 1'b1, ADDR_W'(100), 1'b0, 1'b0, g);
        repeat (5) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, g);
        cycle(1'b0, '0, 1'b1, ADDR_W'(101), 1'b0, 1'b0, g);
        cycle(1'b0, '0, 1'b1, ADDR_W'(102), 1'b0, 1'b0, g);
        rst = 1'b1;
        repeat (2) cycle(1'b0, '0, 1'b1, ADDR_W'(103), 1'b1, 1'b0, g);
        rst = 1'b0;
        repeat (6) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, g);
        repeat (6) cycle(1'b0, '0, 1'b1, ADDR_W'(200), 1'b0, 1'b0, g);
        repeat (10) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, g);

        // Scaled-down frame (100x60 timing, 80x48 active) with random secondary traffic.
        for (int y = 0; y < 60; y++) begin
            for (int x = 0; x < 100; x++) begin
                rst = (y == 30 && (x == 10 || x == 11));
                cycle((x < 80 && y < 48), ADDR_W'(y * 640 + x),
                      ($urandom_range(0, 9) < 6), ADDR_W'($urandom_range(0, 307199)),
                      ($urandom_range(0, 9) < 5), ($urandom_range(0, 499) == 0), g);
            end
        end
        rst = 1'b0;
        repeat (12) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
